// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, branch flush and
// data-memory wait freeze, plus a saturating stall-cycle counter and a sticky
// memory-timeout flag.
module hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic [4:0]             id_RegDst_i,
    input  logic                   id_RegWEn_i,
    input  logic [1:0]             id_WBSel_i,
    input  logic                   id_MemOp_i,
    input  logic                   ex_branch_taken_i,
    input  logic                   dmem_ready_i,
    input  logic                   perf_clr_i,
    output logic                   hazard_o,
    output logic                   pc_we_o,
    output logic                   ifid_we_o,
    output logic                   ifid_flush_o,
    output logic                   freeze_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   mem_timeout_o
);

    localparam logic STATE_RUN      = 1'b0;
    localparam logic STATE_MEM_WAIT = 1'b1;

    // Scoreboard entries for the instructions currently in EX and MEM.
    logic       ex_valid_q, ex_wen_q, ex_load_q, ex_mem_q;
    logic [4:0] ex_rd_q;
    logic       mem_valid_q, mem_wen_q, mem_load_q, mem_mem_q;
    logic [4:0] mem_rd_q;

    logic                   state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic rs1_hit, rs2_hit, load_use;

    // MEM-stage rd/wen/is_load are tracked for completeness but not consumed here.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{mem_rd_q, mem_wen_q, mem_load_q};

    assign mem_wait = mem_valid_q & mem_mem_q & ~dmem_ready_i;
    assign rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_q);
    assign rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_q);
    // Loads to x0 never produce a value worth waiting for.
    assign load_use = ex_valid_q & ex_load_q & ex_wen_q & (ex_rd_q != 5'd0) & (rs1_hit | rs2_hit);

    // Output decode with priority freeze > flush > load-use; reset forces idle values.
    always_comb begin
        hazard_o     = 1'b0;
        pc_we_o      = 1'b1;
        ifid_we_o    = 1'b1;
        ifid_flush_o = 1'b0;
        freeze_o     = 1'b0;
        if (!rst_i) begin
            if (mem_wait) begin
                freeze_o  = 1'b1;
                pc_we_o   = 1'b0;
                ifid_we_o = 1'b0;
            end else if (ex_branch_taken_i) begin
                ifid_flush_o = 1'b1;
                hazard_o     = 1'b1;
            end else if (load_use) begin
                hazard_o  = 1'b1;
                pc_we_o   = 1'b0;
                ifid_we_o = 1'b0;
            end
        end
    end

    // FSM next state, wait counter, timeout flag and stall counter next values.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_RUN:      if (mem_wait) state_d = STATE_MEM_WAIT;
            STATE_MEM_WAIT: if (dmem_ready_i) state_d = STATE_RUN;
            default:        state_d = STATE_RUN;
        endcase

        // Counts consecutive waiting cycles; drops to zero once the access completes.
        wait_cnt_d = 8'd0;
        if (mem_wait) begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (32'(wait_cnt_d) == MEM_TIMEOUT);

        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if ((hazard_o | freeze_o) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Scoreboard advance: held while frozen, bubble into EX on a hazard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wen_q    <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_mem_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wen_q   <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_mem_q   <= 1'b0;
        end else if (!mem_wait) begin
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_wen_q   <= ex_wen_q;
            mem_load_q  <= ex_load_q;
            mem_mem_q   <= ex_mem_q;
            if (hazard_o) begin
                ex_valid_q <= 1'b0;
                ex_rd_q    <= 5'd0;
                ex_wen_q   <= 1'b0;
                ex_load_q  <= 1'b0;
                ex_mem_q   <= 1'b0;
            end else begin
                ex_valid_q <= 1'b1;
                ex_rd_q    <= id_RegDst_i;
                ex_wen_q   <= id_RegWEn_i;
                ex_load_q  <= (id_WBSel_i == 2'b00);
                ex_mem_q   <= id_MemOp_i;
            end
        end
    end

    // FSM, wait counter, sticky timeout and stall counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= STATE_RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_hazard_ctrl;

    localparam int unsigned CW   = 16;
    localparam int unsigned TO   = 255;
    localparam int unsigned SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, regdst;
    logic          use1, use2, regwen, memop, branch, ready, perf_clr;
    logic [1:0]    wbsel;
    logic          hazard, pc_we, ifid_we, flush, freeze, timeout;
    logic [CW-1:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    hazard_ctrl #(.STALL_CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (rs1),
        .id_rs2_i          (rs2),
        .id_use_rs1_i      (use1),
        .id_use_rs2_i      (use2),
        .id_RegDst_i       (regdst),
        .id_RegWEn_i       (regwen),
        .id_WBSel_i        (wbsel),
        .id_MemOp_i        (memop),
        .ex_branch_taken_i (branch),
        .dmem_ready_i      (ready),
        .perf_clr_i        (perf_clr),
        .hazard_o          (hazard),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .ifid_flush_o      (flush),
        .freeze_o          (freeze),
        .stall_cnt_o       (stall_cnt),
        .mem_timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       load;
        logic       mem;
    } sb_t;

    typedef struct packed {
        logic hazard;
        logic pc_we;
        logic ifid_we;
        logic flush;
        logic freeze;
    } out_t;

    sb_t         m_ex, m_mem;
    int unsigned m_stall, m_wait;
    logic        m_to;

    task automatic model_reset();
        m_ex    = '0;
        m_mem   = '0;
        m_stall = 0;
        m_wait  = 0;
        m_to    = 1'b0;
    endtask

    function automatic out_t model_out();
        out_t o;
        logic waiting, lu;
        o.hazard  = 1'b0;
        o.pc_we   = 1'b1;
        o.ifid_we = 1'b1;
        o.flush   = 1'b0;
        o.freeze  = 1'b0;
        if (rst) return o;
        waiting = m_mem.valid && m_mem.mem && !ready;
        lu = m_ex.valid && m_ex.load && m_ex.wen && (m_ex.rd != 5'd0) &&
             ((use1 && rs1 == m_ex.rd) || (use2 && rs2 == m_ex.rd));
        if (waiting) begin
            o.freeze  = 1'b1;
            o.pc_we   = 1'b0;
            o.ifid_we = 1'b0;
        end else if (branch) begin
            o.flush  = 1'b1;
            o.hazard = 1'b1;
        end else if (lu) begin
            o.hazard  = 1'b1;
            o.pc_we   = 1'b0;
            o.ifid_we = 1'b0;
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state update on each clock edge.
    initial forever begin
        out_t o;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            o = model_out();
            if (perf_clr) m_stall = 0;
            else if ((o.hazard || o.freeze) && m_stall < SMAX) m_stall++;
            if (o.freeze) begin
                if (m_wait < 255) m_wait++;
                if (m_wait == TO) m_to = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (!o.freeze) begin
                m_mem = m_ex;
                if (o.hazard) m_ex = '0;
                else m_ex = {1'b1, regdst, regwen, (wbsel == 2'b00), memop};
            end
        end
    end

    // Asynchronous reset also clears the model immediately.
    initial forever begin
        @(posedge rst);
        model_reset();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        out_t e;
        @(negedge clk);
        e = model_out();
        check("hazard_o",      32'(hazard),    32'(e.hazard));
        check("pc_we_o",       32'(pc_we),     32'(e.pc_we));
        check("ifid_we_o",     32'(ifid_we),   32'(e.ifid_we));
        check("ifid_flush_o",  32'(flush),     32'(e.flush));
        check("freeze_o",      32'(freeze),    32'(e.freeze));
        check("stall_cnt_o",   32'(stall_cnt), m_stall);
        check("mem_timeout_o", 32'(timeout),   32'(m_to));
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        regdst = 5'd0; regwen = 1'b0; wbsel = 2'b01; memop = 1'b0;
        branch = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_lw(input logic [4:0] rd);
        set_nop();
        regdst = rd; regwen = 1'b1; wbsel = 2'b00; memop = 1'b1;
    endtask

    task automatic set_use(input logic [4:0] a, input logic ua, input logic [4:0] b,
                           input logic ub);
        set_nop();
        rs1 = a; use1 = ua; rs2 = b; use2 = ub;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        set_nop();
        ready  = 1'b1;
        branch = 1'b1;  // must not leak through while in reset
        repeat (2) @(negedge clk);
        check("rst_hazard", 32'(hazard), 0);
        check("rst_flush",  32'(flush),  0);
        check("rst_pc_we",  32'(pc_we),  1);
        check("rst_stall",  32'(stall_cnt), 0);

        // Load-use: one bubble, then proceed.
        next_cycle(); rst = 1'b0; set_lw(5'd5);
        next_cycle(); set_use(5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("lu_hazard", 32'(hazard), 1);
        check("lu_pc_we",  32'(pc_we),  0);
        next_cycle();
        @(negedge clk);
        check("lu_release", 32'(hazard), 0);
        check("lu_stall1",  32'(stall_cnt), 1);

        // lw x0 and unused rs2 never stall; used rs2 does.
        next_cycle(); set_lw(5'd0);
        next_cycle(); set_use(5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk); check("x0_no_hazard", 32'(hazard), 0);
        next_cycle(); set_lw(5'd6);
        next_cycle(); set_use(5'd1, 1'b1, 5'd6, 1'b0);
        @(negedge clk); check("rs2_unused", 32'(hazard), 0);
        next_cycle(); set_lw(5'd6);
        next_cycle(); set_use(5'd1, 1'b1, 5'd6, 1'b1);
        @(negedge clk); check("rs2_used", 32'(hazard), 1);

        // Memory wait with a pending load-use behind it, branch ignored while frozen.
        next_cycle(); set_lw(5'd7);
        next_cycle(); set_lw(5'd8);
        next_cycle(); set_use(5'd8, 1'b1, 5'd0, 1'b0); ready = 1'b0;
        @(negedge clk);
        check("mw_freeze",    32'(freeze), 1);
        check("mw_no_hazard", 32'(hazard), 0);
        check("mw_stall2",    32'(stall_cnt), 2);
        next_cycle(); branch = 1'b1;
        @(negedge clk);
        check("mw_branch_ignored", 32'(flush), 0);
        next_cycle(); branch = 1'b0;
        next_cycle(); ready = 1'b1;
        @(negedge clk);
        check("mw_unfrozen",   32'(freeze), 0);
        check("mw_held_lu",    32'(hazard), 1);
        check("mw_stall_plus3", 32'(stall_cnt), 5);
        next_cycle();
        @(negedge clk); check("mw_after", 32'(stall_cnt), 6);

        // Branch coinciding with load-use is a flush.
        next_cycle(); set_lw(5'd9);
        next_cycle(); set_use(5'd9, 1'b1, 5'd0, 1'b0); branch = 1'b1;
        @(negedge clk);
        check("br_flush",  32'(flush),  1);
        check("br_hazard", 32'(hazard), 1);
        check("br_pc_we",  32'(pc_we),  1);

        // Timeout after 255 waiting cycles, then async reset mid-wait.
        next_cycle(); set_lw(5'd10);
        next_cycle(); set_nop();
        next_cycle(); ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (i == 254) check("to_not_yet", 32'(timeout), 0);
            if (i == 255) check("to_set",     32'(timeout), 1);
        end
        check("to_sticky", 32'(timeout), 1);
        #2; rst = 1'b1; branch = 1'b1;
        #1;
        check("arst_freeze",  32'(freeze),    0);
        check("arst_flush",   32'(flush),     0);
        check("arst_pc_we",   32'(pc_we),     1);
        check("arst_ifid_we", 32'(ifid_we),   1);
        check("arst_stall",   32'(stall_cnt), 0);
        check("arst_timeout", 32'(timeout),   0);
        next_cycle(); rst = 1'b0; branch = 1'b0; ready = 1'b1;

        // Saturate the stall counter, then clear it during a stall.
        next_cycle(); set_lw(5'd11);
        next_cycle(); set_nop();
        next_cycle(); ready = 1'b0;
        repeat (65540) @(negedge clk);
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        next_cycle(); perf_clr = 1'b1;
        @(negedge clk); check("clr_with_stall_freeze", 32'(freeze), 1);
        next_cycle(); perf_clr = 1'b0; ready = 1'b1;
        @(negedge clk); check("clr_zero", 32'(stall_cnt), 0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            use1     = 1'($urandom_range(0, 1));
            use2     = 1'($urandom_range(0, 1));
            regdst   = 5'($urandom_range(0, 3));
            regwen   = 1'($urandom_range(0, 1));
            wbsel    = 2'($urandom_range(0, 3));
            memop    = 1'($urandom_range(0, 1));
            branch   = ($urandom_range(0, 99) < 15);
            ready    = ($urandom_range(0, 99) < 75);
            perf_clr = ($urandom_range(0, 99) < 2);
            rst      = ($urandom_range(0, 199) == 0);
        end
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
